// File: rtl/data_pkg.sv
// Shared types and default sizing for the generator-stream checker.
package data_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int DATA_W        = 8;
    localparam int LOCK_CNT_DEF  = 4;
    localparam int LOSS_CNT_DEF  = 3;
    localparam int STUCK_CNT_DEF = 8;
    localparam int ERR_W_DEF     = 16;

endpackage

// File: rtl/data_chk_if.sv
// Sample/control inputs and status outputs of the stream checker.
// master = source/status consumer side, slave = the checker.
interface data_chk_if
    import data_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int ERR_W = ERR_W_DEF
);
    logic             en;
    logic [DW-1:0]    data_in;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             stuck;

    modport master (
        output en, data_in, clr_cnt,
        input  locked, err_pulse, err_cnt, stuck
    );

    modport slave (
        input  en, data_in, clr_cnt,
        output locked, err_pulse, err_cnt, stuck
    );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter: clear wins over increment within a cycle, never wraps.
// Latency 1 cycle (registered count); no backpressure.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear first, then count, so a clear and an increment together yield 1.
    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q;
        if (inc_i && (cnt_d != {W{1'b1}})) begin
            cnt_d = cnt_d + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/data_chk.sv
// Checker for the self-incrementing generator stream: locks, counts breaks, flags a stuck source.
// All outputs registered, 1 cycle after the sample; en low freezes every register.
module data_chk
    import data_pkg::*;
#(
    parameter int DW        = DATA_W,
    parameter int LOCK_CNT  = LOCK_CNT_DEF,
    parameter int LOSS_CNT  = LOSS_CNT_DEF,
    parameter int STUCK_CNT = STUCK_CNT_DEF,
    parameter int ERR_W     = ERR_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    data_chk_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam int SAME_W = $clog2(STUCK_CNT + 1);

    chk_state_t  state_q, state_d;
    logic [DW-1:0]     prev_q, prev_d;
    logic              have_prev_q, have_prev_d;
    logic [DW-1:0]     expected_q, expected_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [SAME_W-1:0] same_q, same_d;
    logic              err_pulse_q, err_pulse_d;
    logic              stuck_q, stuck_d;
    logic              err_inc;

    logic              en;
    logic [DW-1:0]     data;
    logic              seq_ok;
    logic              hit;
    logic              repeat_ok;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;

    assign en        = bus.en;
    assign data      = bus.data_in;
    assign seq_ok    = have_prev_q && (data == prev_q + DW'(1));
    assign hit       = (data == expected_q);
    assign repeat_ok = have_prev_q && (data == prev_q);
    assign run_inc   = seq_ok ? run_q + RUN_W'(1) : '0;
    assign miss_inc  = miss_q + MISS_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                SEARCH: if (run_inc == RUN_W'(LOCK_CNT)) state_d = LOCKED;
                LOCKED: if (!hit && (miss_inc == MISS_W'(LOSS_CNT))) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        expected_d  = expected_q;
        run_d       = run_q;
        miss_d      = miss_q;
        same_d      = same_q;
        stuck_d     = stuck_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        if (en) begin
            prev_d      = data;
            have_prev_d = 1'b1;
            if (repeat_ok) begin
                same_d = (same_q == SAME_W'(STUCK_CNT)) ? same_q : same_q + SAME_W'(1);
            end else begin
                same_d = '0;
            end
            stuck_d = (same_d == SAME_W'(STUCK_CNT));
            case (state_q)
                SEARCH: begin
                    run_d = run_inc;
                    if (run_inc == RUN_W'(LOCK_CNT)) begin
                        expected_d = data + DW'(1);
                        miss_d     = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: expected advances regardless, so one bad word costs one error.
                    expected_d = expected_q + DW'(1);
                    if (!hit) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        miss_d      = miss_inc;
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            run_d = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            expected_q  <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            same_q      <= '0;
            err_pulse_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            same_q      <= same_d;
            err_pulse_q <= err_pulse_d;
            stuck_q     <= stuck_d;
        end
    end

    sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (en & bus.clr_cnt),
        .inc_i (err_inc),
        .cnt_o (bus.err_cnt)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.stuck     = stuck_q;
endmodule

// File: tb/tb_data_chk.sv
// Directed scenarios plus random traffic, checked every cycle against a sequence-rule model.
module tb_data_chk;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_chk_if #(.DW(8), .ERR_W(16)) b16 ();
    data_chk_if #(.DW(8), .ERR_W(2))  b2 ();

    data_chk #(.ERR_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
    data_chk #(.ERR_W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers, rules applied per accepted word.
    int m_prev, m_exp, m_run, m_miss, m_same, m_err, m_err2;
    bit m_have, m_locked, m_pulse, m_stuck;
    int last_word;

    task automatic model_reset();
        m_prev = 0; m_exp = 0; m_run = 0; m_miss = 0; m_same = 0;
        m_err = 0; m_err2 = 0; m_have = 0; m_locked = 0; m_pulse = 0; m_stuck = 0;
    endtask

    task automatic model_update(input bit e, input int d, input bit c);
        m_pulse = 0;
        if (!e) return;
        if (c) begin m_err = 0; m_err2 = 0; end
        if (!m_locked) begin
            m_run = (m_have && d == (m_prev + 1) % 256) ? m_run + 1 : 0;
            if (m_run == 4) begin
                m_locked = 1; m_exp = (d + 1) % 256; m_miss = 0;
            end
        end else begin
            if (d != m_exp) begin
                m_pulse = 1;
                if (m_err < 65535) m_err++;
                if (m_err2 < 3) m_err2++;
                m_miss++;
                if (m_miss == 3) begin m_locked = 0; m_run = 0; end
            end else begin
                m_miss = 0;
            end
            m_exp = (m_exp + 1) % 256;
        end
        if (m_have && d == m_prev) m_same = (m_same < 8) ? m_same + 1 : 8;
        else m_same = 0;
        m_stuck = (m_same == 8);
        m_prev = d; m_have = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("locked",    32'(b16.locked),    32'(m_locked));
        chk("err_pulse", 32'(b16.err_pulse), 32'(m_pulse));
        chk("err_cnt",   32'(b16.err_cnt),   32'(m_err));
        chk("stuck",     32'(b16.stuck),     32'(m_stuck));
        chk("err_cnt_w2", 32'(b2.err_cnt),   32'(m_err2));
        chk("locked_w2", 32'(b2.locked),     32'(m_locked));
    endtask

    task automatic step(input bit e, input int d, input bit c);
        @(negedge clk);
        b16.en = e; b16.data_in = 8'(d); b16.clr_cnt = c;
        b2.en  = e; b2.data_in  = 8'(d); b2.clr_cnt  = c;
        if (e) last_word = d;
        @(posedge clk);
        model_update(e, d, c);
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        b16.en = 1'b0; b2.en = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int d;
        b16.en = 1'b0; b16.data_in = '0; b16.clr_cnt = 1'b0;
        b2.en  = 1'b0; b2.data_in  = '0; b2.clr_cnt  = 1'b0;
        model_reset();
        last_word = 0;
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Lock-in, continuing through the wrap and up to 0x0F
        for (int i = 0; i < 10; i++) begin
            step(1, i, 0);
            chk("lockin_edge", 32'(b16.locked), 32'(i >= 4));
        end
        for (int i = 10; i < 256 + 16; i++) begin
            step(1, i % 256, 0);
            if (i % 256 >= 252 || i % 256 <= 1) chk("wrap_locked", 32'(b16.locked), 32'd1);
        end
        chk("wrap_no_err", 32'(b16.err_cnt), 32'd0);

        // Single corruption
        step(1, 'h10, 0); step(1, 'h11, 0); step(1, 'h55, 0);
        chk("single_pulse", 32'(b16.err_pulse), 32'd1);
        step(1, 'h13, 0);
        chk("single_pulse_end", 32'(b16.err_pulse), 32'd0);
        step(1, 'h14, 0);
        chk("single_cnt", 32'(b16.err_cnt), 32'd1);
        chk("single_locked", 32'(b16.locked), 32'd1);

        // Lock loss and relock
        step(1, 'h15, 1);
        for (int i = 'h16; i <= 'h20; i++) step(1, i, 0);
        step(1, 'hAA, 0); step(1, 'hBB, 0);
        chk("loss_still_locked", 32'(b16.locked), 32'd1);
        step(1, 'hCC, 0);
        chk("loss_locked_fall", 32'(b16.locked), 32'd0);
        chk("loss_cnt", 32'(b16.err_cnt), 32'd3);
        for (int i = 'h24; i <= 'h28; i++) begin
            step(1, i, 0);
            chk("relock_edge", 32'(b16.locked), 32'(i == 'h28));
        end

        // Constant source from a fresh reset
        pulse_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1, 'hFF, 0);
            chk("const_stuck", 32'(b16.stuck), 32'(i >= 9));
            chk("const_nolock", 32'(b16.locked), 32'd0);
        end
        step(1, 'h00, 0);
        chk("const_stuck_fall", 32'(b16.stuck), 32'd0);

        // Gaps in en during a locked count
        for (int i = 1; i <= 6; i++) step(1, i, 0);
        for (int i = 7; i <= 20; i++) begin
            step(1, i, 0);
            step(0, 'h99, 0);
        end
        chk("gap_no_err", 32'(b16.err_cnt), 32'd0);
        chk("gap_locked", 32'(b16.locked), 32'd1);

        // Clear coinciding with a mismatch
        step(1, 'h15, 0); step(1, 'h77, 0);
        step(1, 'h17, 0); step(1, 'h78, 1);
        chk("clr_and_miss", 32'(b16.err_cnt), 32'd1);

        // Saturation of a 2-bit counter: five spaced mismatches after a clear
        step(1, 'h19, 1);
        d = 'h1A;
        for (int k = 0; k < 5; k++) begin
            step(1, (d + 'h40) % 256, 0); d++;
            step(1, d, 0); d++;
        end
        chk("sat_w2", 32'(b2.err_cnt), 32'd3);
        chk("sat_w16", 32'(b16.err_cnt), 32'd5);

        // Asynchronous reset mid-lock, checked before the next edge
        chk("pre_reset_locked", 32'(b16.locked), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic: mostly incrementing words, with corruptions, repeats, gaps, clears
        last_word = 0;
        for (int n = 0; n < 3000; n++) begin
            int r, w;
            bit e, c;
            r = int'($urandom_range(0, 99));
            e = ($urandom_range(0, 99) < 85);
            c = ($urandom_range(0, 99) < 2);
            if (r < 80)      w = (last_word + 1) % 256;
            else if (r < 90) w = last_word;
            else             w = int'($urandom_range(0, 255));
            step(e, w, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_chk.md
# data_chk

Downstream checker for the 8-bit self-incrementing stream from the data generator. It samples `data_in` on every enabled cycle and locks onto the increment sequence. Once locked, it flags and counts words that break the sequence, and it separately reports a stuck (non-changing) source. Its outputs go to status registers and to the simulation bench as the pass/fail indicator for the generator path.

## Interface
- `DW`, 8: data width; increment is modulo 2^DW.
- `LOCK_CNT`, 4: consecutive correct increments needed to enter LOCKED.
- `LOSS_CNT`, 3: consecutive mismatches in LOCKED that drop lock.
- `STUCK_CNT`, 8: consecutive equal samples that assert `stuck`.
- `ERR_W`, 16: error counter width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  `data_in` valid this cycle; when low, all state holds.
- `data_in`  in  DW  word from the generator.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  checker is in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per mismatched word while LOCKED.
- `err_cnt`  out  ERR_W  saturating count of mismatches.
- `stuck`  out  1  source has not changed for STUCK_CNT samples.

## Operation
- Internal state:
  - `prev` (last sampled word) and `have_prev` (cleared by reset).
  - `expected`.
  - `run` (match run length).
  - `miss` (consecutive misses).
  - `same` (equal-sample run).
  - FSM {SEARCH, LOCKED}.
- All updates happen only on cycles with `en`=1. Every enabled sample writes `prev` <= `data_in` and `have_prev` <= 1.
- SEARCH:
  - Match means `have_prev` and `data_in` == `prev`+1 (mod 2^DW).
  - On a match, `run`++; otherwise `run` <= 0. The first sample after reset never matches.
  - When a sample brings `run` to LOCK_CNT: go to LOCKED, set `expected` <= `data_in`+1, `miss` <= 0.
  - No errors are counted in SEARCH.
- LOCKED:
  - `expected` advances by 1 on every enabled sample, whether or not the word matched (flywheel). A single corrupted word therefore costs exactly one error.
  - On a mismatch: `err_pulse`, `err_cnt` saturating increment, `miss`++.
  - On a match: `miss` <= 0.
  - When a mismatch brings `miss` to LOSS_CNT: go to SEARCH, `run` <= 0.
- Wrap-around: FF->00 is a valid increment in both states.
- Stuck detection:
  - If `have_prev` and `data_in` == `prev`, then `same`++, saturating at STUCK_CNT; otherwise `same` <= 0.
  - `stuck` = (`same` == STUCK_CNT). It is independent of FSM state.
- `err_cnt` saturates at all-ones and never wraps.
- `clr_cnt` together with a mismatch in the same cycle gives `err_cnt` = 1: the clear applies first, then the count.
- `en` low: `err_pulse` is 0; no counter, FSM or register changes.

## Timing
- All outputs are registered. Each one reflects the sample taken on the previous rising edge.
- `err_pulse` is high for exactly the one cycle after the offending sample.
- `locked` rises the cycle after the LOCK_CNT-th matching sample. It falls the cycle after the LOSS_CNT-th consecutive miss.
- `stuck` rises the cycle after the sample that brings `same` to STUCK_CNT. It falls the cycle after the first differing sample.
- Reset (`rst`=0), asynchronous and allowed at any time, including mid-lock:
  - FSM goes to SEARCH; `locked`, `err_pulse` and `stuck` go to 0; `err_cnt` goes to 0.
  - `have_prev`, `run`, `miss` and `same` clear. `prev` and `expected` clear to 0.
  - The first enabled sample after reset release never matches.

## Structure
- Package `data_pkg` holds:
  - the `chk_state_t` enum {SEARCH, LOCKED};
  - default constants DATA_W=8, LOCK_CNT_DEF=4, LOSS_CNT_DEF=3, STUCK_CNT_DEF=8.
- One sub-module, `sat_cnt`: a parameterised saturating up-counter with synchronous clear and increment enable.
  - One instance serves as `err_cnt`.
  - `run`, `miss` and `same` are small local counters and stay in `data_chk`.

## Test plan
All scenarios use default parameters and `en`=1 unless stated.
- Lock-in: release reset, feed 00,01,…,09 → `locked` rises the cycle after sample 04; `err_pulse` never fires; `err_cnt`=0.
- Wrap-around: lock, then feed FC,FD,FE,FF,00,01 → `locked` stays 1; `err_cnt`=0.
- Single corruption: locked, feed 10,11,55,13,14 → one `err_pulse` the cycle after 55; `err_cnt`=1; `locked` stays 1.
- Lock loss:
  - Stimulus: locked on …,20, then feed AA,BB,CC,24,25,26.
  - Response: three `err_pulse` cycles; `err_cnt`=3; `locked` falls the cycle after CC.
  - Then: relocks the cycle after the 4th increment-matching sample that follows.
- Constant source: feed FF for 20 cycles → `locked` never rises; `stuck` rises the cycle after the 9th sample; `err_cnt`=0. Then feed 00 → `stuck` falls the cycle after.
- Control and reset:
  - Gaps: `en` toggled 1/0 during a locked count → no errors across the gaps.
  - Clear: `clr_cnt` in the same cycle as a mismatch → `err_cnt`=1.
  - Saturation: `ERR_W`=2 with 5 mismatches → `err_cnt`=3.
  - Mid-lock reset: assert `rst` low → all outputs 0 before the next clock edge.
